// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and load/store,
// one transaction in flight; data wins unless fetch has waited STARVE_LIMIT grants.
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_ack_o,
    output logic [31:0] if_rdata_o,
    input  logic        dm_req_i,
    input  logic        dm_we_i,
    input  logic [3:0]  dm_be_i,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_wdata_i,
    output logic        dm_ack_o,
    output logic [31:0] dm_rdata_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_e;
    typedef enum logic {OWN_FETCH, OWN_DATA} owner_e;

    state_e          state_q, state_d;
    owner_e          owner_q, owner_d;
    logic [CW-1:0]   starve_q, starve_d;
    logic            we_q, we_d;
    logic [3:0]      be_q, be_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     if_rdata_q, if_rdata_d;
    logic [31:0]     dm_rdata_q, dm_rdata_d;
    logic            fetch_starved;

    assign fetch_starved = (starve_q == CW'(STARVE_LIMIT));

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        starve_d   = starve_q;
        we_d       = we_q;
        be_d       = be_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (dm_req_i && !(if_req_i && fetch_starved)) begin
                    owner_d  = OWN_DATA;
                    we_d     = dm_we_i;
                    be_d     = dm_we_i ? dm_be_i : 4'hF;
                    addr_d   = dm_addr_i;
                    wdata_d  = dm_we_i ? dm_wdata_i : 32'h0;
                    // Count only data wins that actually made fetch wait.
                    if (!if_req_i)
                        starve_d = '0;
                    else if (!fetch_starved)
                        starve_d = starve_q + CW'(1);
                    state_d  = S_REQ;
                end else if (if_req_i) begin
                    owner_d  = OWN_FETCH;
                    we_d     = 1'b0;
                    be_d     = 4'hF;
                    addr_d   = if_addr_i;
                    wdata_d  = 32'h0;
                    starve_d = '0;
                    state_d  = S_REQ;
                end
            end
            S_REQ: begin
                if (mem_gnt_i)
                    state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mem_rvalid_i) begin
                    if (owner_q == OWN_FETCH)
                        if_rdata_d = mem_rdata_i;
                    else
                        dm_rdata_d = mem_rdata_i;
                    state_d = S_RESP;
                end
            end
            S_RESP: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q    <= S_IDLE;
            owner_q    <= OWN_FETCH;
            starve_q   <= '0;
            we_q       <= 1'b0;
            be_q       <= 4'h0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            if_rdata_q <= 32'h0;
            dm_rdata_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            starve_q   <= starve_d;
            we_q       <= we_d;
            be_q       <= be_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

    assign mem_req_o   = (state_q == S_REQ);
    assign mem_we_o    = we_q;
    assign mem_be_o    = be_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign if_ack_o    = (state_q == S_RESP) && (owner_q == OWN_FETCH);
    assign dm_ack_o    = (state_q == S_RESP) && (owner_q == OWN_DATA);
    assign if_rdata_o  = if_rdata_q;
    assign dm_rdata_o  = dm_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, reset/contention/back-to-back
// sequences, and randomized traffic against a request-level arbitration model.
module tb_mem_port_arbiter;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [3:0]  dm_be = '0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic        dm_ack;
    logic [31:0] dm_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int streak = 0;

    mem_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk_i(clk), .reset_n_i(reset_n),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_ack_o(if_ack), .if_rdata_o(if_rdata),
        .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_be_i(dm_be), .dm_addr_i(dm_addr),
        .dm_wdata_i(dm_wdata), .dm_ack_o(dm_ack), .dm_rdata_o(dm_rdata),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid),
        .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory-side responder: waits for mem_req, grants after gdly cycles of request,
    // returns rvalid rdly cycles after grant, then samples the ack cycle.
    task automatic serve(input int gdly, input int rdly, input logic [31:0] rd,
                         output bit saw_if, output bit saw_dm, output logic we,
                         output logic [3:0] be, output logic [31:0] addr,
                         output logic [31:0] wd, output int req_cyc, output int ack_cyc);
        int n;
        bit early;
        saw_if = 0; saw_dm = 0; early = 0;
        we = 0; be = 0; addr = 0; wd = 0; req_cyc = 0; ack_cyc = 0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (if_ack || dm_ack) early = 1;
        end while (!mem_req && n < 8);
        if (!mem_req) begin
            chk("mem_req_timeout", {31'b0, mem_req}, 32'h1);
            return;
        end
        req_cyc = cyc; we = mem_we; be = mem_be; addr = mem_addr; wd = mem_wdata;
        for (int i = 1; i < gdly; i++) begin
            @(negedge clk);
            if (if_ack || dm_ack) early = 1;
            chk("req_held", {31'b0, mem_req}, 32'h1);
            chk("addr_held", mem_addr, addr);
        end
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        chk("req_drop_after_gnt", {31'b0, mem_req}, 32'h0);
        if (if_ack || dm_ack) early = 1;
        for (int i = 1; i < rdly; i++) begin
            @(negedge clk);
            if (if_ack || dm_ack || mem_req) early = 1;
        end
        mem_rvalid = 1'b1;
        mem_rdata = rd;
        @(negedge clk);
        mem_rvalid = 1'b0;
        mem_rdata = $urandom;
        saw_if = if_ack; saw_dm = dm_ack; ack_cyc = cyc;
        chk("no_early_ack", {31'b0, early}, 32'h0);
    endtask

    // Reference arbitration rule: data wins unless fetch has already lost LIMIT times in a row.
    function automatic bit pick_fetch(input bit ifp, input bit dmp);
        if (!dmp) return 1'b1;
        if (!ifp) return 1'b0;
        return (streak >= LIMIT);
    endfunction

    function automatic void note_grant(input bit fetch, input bit ifp);
        if (!fetch && ifp) streak = (streak < LIMIT) ? streak + 1 : LIMIT;
        else streak = 0;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_mem_req"}, {31'b0, mem_req}, 32'h0);
        chk({tag, "_mem_we"}, {31'b0, mem_we}, 32'h0);
        chk({tag, "_mem_be"}, {28'b0, mem_be}, 32'h0);
        chk({tag, "_mem_addr"}, mem_addr, 32'h0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
        chk({tag, "_if_ack"}, {31'b0, if_ack}, 32'h0);
        chk({tag, "_dm_ack"}, {31'b0, dm_ack}, 32'h0);
        chk({tag, "_if_rdata"}, if_rdata, 32'h0);
        chk({tag, "_dm_rdata"}, dm_rdata, 32'h0);
    endtask

    typedef struct {
        string       name;
        bit          ifr;
        bit          dmr;
        bit          we;
        logic [3:0]  be;
        logic [31:0] ia;
        logic [31:0] da;
        logic [31:0] wd;
        logic [31:0] rd;
        int          gd;
        int          rdl;
        bit          exp_f;
        logic [3:0]  exp_be;
        logic [31:0] exp_addr;
        logic [31:0] exp_wd;
    } vec_t;

    vec_t vecs[6];

    initial begin
        bit          s_if, s_dm, mwe;
        logic [3:0]  mbe;
        logic [31:0] maddr, mwd;
        int          rq, ak, prev_ak;
        bit          order[10];
        bit          ifp, dmp, ef, last_dm_ok;
        logic [31:0] last_if, last_dm, rdv;
        logic [31:0] e_addr, e_wd;
        logic [3:0]  e_be;
        bit          e_we;

        vecs[0] = '{"load",       0, 1, 0, 4'h3, 32'h0,    32'h100, 32'h1234,     32'hDEADBEEF, 1, 2, 0, 4'hF, 32'h100,  32'h0};
        vecs[1] = '{"store_byte", 0, 1, 1, 4'h4, 32'h0,    32'h204, 32'h00AA0000, 32'h0,        3, 1, 0, 4'h4, 32'h204,  32'h00AA0000};
        vecs[2] = '{"fetch_slow", 1, 0, 0, 4'h0, 32'h2000, 32'h0,   32'h0,        32'h00000013, 5, 2, 1, 4'hF, 32'h2000, 32'h0};
        vecs[3] = '{"fetch",      1, 0, 1, 4'h1, 32'h40,   32'h0,   32'h5555,     32'hCAFEF00D, 1, 1, 1, 4'hF, 32'h40,   32'h0};
        vecs[4] = '{"both_data",  1, 1, 0, 4'h2, 32'h44,   32'h300, 32'h9999,     32'h01020304, 2, 3, 0, 4'hF, 32'h300,  32'h0};
        vecs[5] = '{"store_full", 0, 1, 1, 4'hF, 32'h0,    32'h8,   32'h11223344, 32'h0,        1, 1, 0, 4'hF, 32'h8,    32'h11223344};

        // Reset values
        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        reset_n = 1'b1;
        @(negedge clk);

        // Directed table
        foreach (vecs[k]) begin
            if_req = vecs[k].ifr; if_addr = vecs[k].ia;
            dm_req = vecs[k].dmr; dm_we = vecs[k].we; dm_be = vecs[k].be;
            dm_addr = vecs[k].da; dm_wdata = vecs[k].wd;
            serve(vecs[k].gd, vecs[k].rdl, vecs[k].rd, s_if, s_dm, mwe, mbe, maddr, mwd, rq, ak);
            chk({vecs[k].name, "_if_ack"}, {31'b0, s_if}, {31'b0, vecs[k].exp_f});
            chk({vecs[k].name, "_dm_ack"}, {31'b0, s_dm}, {31'b0, !vecs[k].exp_f});
            chk({vecs[k].name, "_mem_we"}, {31'b0, mwe}, {31'b0, vecs[k].we && !vecs[k].exp_f});
            chk({vecs[k].name, "_mem_be"}, {28'b0, mbe}, {28'b0, vecs[k].exp_be});
            chk({vecs[k].name, "_mem_addr"}, maddr, vecs[k].exp_addr);
            chk({vecs[k].name, "_mem_wdata"}, mwd, vecs[k].exp_wd);
            chk({vecs[k].name, "_latency"}, ak - rq, vecs[k].gd + vecs[k].rdl);
            if (vecs[k].exp_f) chk({vecs[k].name, "_if_rdata"}, if_rdata, vecs[k].rd);
            else if (!vecs[k].we) chk({vecs[k].name, "_dm_rdata"}, dm_rdata, vecs[k].rd);
            if_req = 0; dm_req = 0;
            @(negedge clk);
            chk({vecs[k].name, "_ack_one_cycle"}, {30'b0, if_ack, dm_ack}, 32'h0);
        end
        chk("if_rdata_hold", if_rdata, 32'hCAFEF00D);

        // Reset in the middle of a load
        dm_req = 1; dm_we = 0; dm_addr = 32'h500;
        @(negedge clk);
        chk("rst_mid_req", {31'b0, mem_req}, 32'h1);
        mem_gnt = 1;
        @(negedge clk);
        mem_gnt = 0;
        reset_n = 0;
        #1;
        chk_all_zero("rst_mid");
        dm_req = 0;
        @(negedge clk);
        reset_n = 1;
        repeat (4) begin
            @(negedge clk);
            chk("rst_abandon_quiet", {29'b0, if_ack, dm_ack, mem_req}, 32'h0);
        end
        streak = 0;
        if_req = 1; if_addr = 32'h80;
        serve(1, 1, 32'h00000013, s_if, s_dm, mwe, mbe, maddr, mwd, rq, ak);
        chk("rst_fresh_if_ack", {30'b0, s_if, s_dm}, 32'h2);
        chk("rst_fresh_addr", maddr, 32'h80);
        chk("rst_fresh_rdata", if_rdata, 32'h00000013);

        // Contention with both requests held continuously
        order = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
        if_req = 1; dm_req = 1; dm_we = 0; dm_addr = 32'h1000; if_addr = 32'h3000;
        for (int i = 0; i < 10; i++) begin
            serve(1 + (i % 2), 1, 32'h100 + i, s_if, s_dm, mwe, mbe, maddr, mwd, rq, ak);
            chk($sformatf("contend_order_%0d", i), {30'b0, s_if, s_dm}, order[i] ? 32'h2 : 32'h1);
            chk($sformatf("contend_addr_%0d", i), maddr, order[i] ? if_addr : dm_addr);
            if (order[i]) if_addr = if_addr + 4; else dm_addr = dm_addr + 4;
        end
        streak = 0;

        // Back-to-back loads, fetch idle
        if_req = 0;
        prev_ak = 0;
        for (int i = 0; i < 3; i++) begin
            serve(1, 1, 32'hB0B0_0000 + i, s_if, s_dm, mwe, mbe, maddr, mwd, rq, ak);
            chk($sformatf("b2b_owner_%0d", i), {30'b0, s_if, s_dm}, 32'h1);
            if (i > 0) chk($sformatf("b2b_gap_%0d", i), rq - prev_ak, 2);
            chk($sformatf("b2b_rdata_%0d", i), dm_rdata, 32'hB0B0_0000 + i);
            prev_ak = ak;
            dm_addr = dm_addr + 4;
        end
        dm_req = 0;
        @(negedge clk);

        // Randomized traffic against the request-level model
        streak = 0; ifp = 0; dmp = 0;
        last_if = if_rdata; last_dm = dm_rdata; last_dm_ok = 1;
        for (int it = 0; it < 200; it++) begin
            if (!ifp && ($urandom_range(0, 1) == 1)) begin
                ifp = 1; if_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!dmp && ($urandom_range(0, 1) == 1 || !ifp)) begin
                dmp = 1; dm_we = $urandom_range(0, 1); dm_be = $urandom_range(0, 15);
                dm_addr = $urandom & 32'hFFFF_FFFC; dm_wdata = $urandom;
            end
            if_req = ifp; dm_req = dmp;
            ef = pick_fetch(ifp, dmp);
            e_we   = ef ? 1'b0 : dm_we;
            e_be   = (ef || !dm_we) ? 4'hF : dm_be;
            e_addr = ef ? if_addr : dm_addr;
            e_wd   = (ef || !dm_we) ? 32'h0 : dm_wdata;
            rdv = $urandom;
            serve($urandom_range(1, 4), $urandom_range(1, 4), rdv, s_if, s_dm, mwe, mbe, maddr, mwd, rq, ak);
            chk("rnd_owner", {30'b0, s_if, s_dm}, ef ? 32'h2 : 32'h1);
            chk("rnd_we", {31'b0, mwe}, {31'b0, e_we});
            chk("rnd_be", {28'b0, mbe}, {28'b0, e_be});
            chk("rnd_addr", maddr, e_addr);
            chk("rnd_wdata", mwd, e_wd);
            if (ef) begin
                chk("rnd_if_rdata", if_rdata, rdv);
                if (last_dm_ok) chk("rnd_dm_hold", dm_rdata, last_dm);
                last_if = rdv;
            end else begin
                if (!dm_we) chk("rnd_dm_rdata", dm_rdata, rdv);
                chk("rnd_if_hold", if_rdata, last_if);
                last_dm = rdv; last_dm_ok = !dm_we;
            end
            note_grant(ef, ifp);
            if (ef) ifp = 0; else dmp = 0;
            if_req = ifp; dm_req = dmp;
            if ($urandom_range(0, 3) == 0) begin
                if_req = 0; dm_req = 0; ifp = 0; dmp = 0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
